// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state and grant encodings shared by the memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, CMD, RDATA, WDATA} mem_arb_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} mem_arb_grant_t;
  localparam int MEM_ARB_LINE_BEATS_DEFAULT = 4;
endpackage

// File: rtl/mem_arb_beat_counter.sv
// mem_arb_beat_counter: burst beat index with clear, increment and last-beat flag; wraps to 0 after the last beat.
module mem_arb_beat_counter #(
  parameter int LINE_BEATS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_i,
  input  logic                          inc_i,
  output logic [$clog2(LINE_BEATS)-1:0] cnt_o,
  output logic                          last_o
);
  localparam int CW = $clog2(LINE_BEATS);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : inc_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt_o  = cnt_q;
  assign last_o = cnt_q == CW'(LINE_BEATS - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-burst memory port between I-cache refills and D-cache refills/writebacks.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; undefined gives fixed D-over-I priority.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = `ADDR_WIDTH,
  parameter int DATA_W     = `DATA_WIDTH,
  parameter int LINE_BEATS = MEM_ARB_LINE_BEATS_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_req_valid,
  input  logic [ADDR_W-1:0]             i_req_addr,
  output logic                          i_req_ready,
  output logic                          i_rdata_valid,
  output logic                          i_rdata_last,
  input  logic                          d_req_valid,
  input  logic                          d_req_write,
  input  logic [ADDR_W-1:0]             d_req_addr,
  output logic                          d_req_ready,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic [$clog2(LINE_BEATS)-1:0] d_wbeat,
  output logic                          d_wdata_ready,
  output logic                          d_rdata_valid,
  output logic                          d_rdata_last,
  output logic [DATA_W-1:0]             rdata,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_write,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic                          mem_wdata_valid,
  input  logic                          mem_wdata_ready,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_rdata_valid,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);
  mem_arb_state_t state_q, state_d;
  mem_arb_grant_t grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic write_q, write_d, pick_d, rd_beat, wr_beat, cnt_last;
  logic [$clog2(LINE_BEATS)-1:0] cnt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;  // 1 when the D-cache held the most recent grant
  assign pick_d = d_req_valid && !(i_req_valid && rr_q);
  assign rr_d   = (state_q == IDLE && (i_req_valid || d_req_valid)) ? pick_d : rr_q;
  always_ff @(posedge clk) rr_q <= rst ? 1'b0 : rr_d;
`else
  assign pick_d = d_req_valid;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      write_q <= write_d;
    end
    addr_q <= addr_d;
  end
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    addr_d          = addr_q;
    write_d         = write_q;
    mem_req_valid   = 1'b0;
    mem_wdata_valid = 1'b0;
    i_req_ready     = 1'b0;
    d_req_ready     = 1'b0;
    rd_beat         = 1'b0;
    wr_beat         = 1'b0;
    case (state_q)
      IDLE: if (i_req_valid || d_req_valid) begin
        state_d = CMD;
        grant_d = pick_d ? GNT_D : GNT_I;
        addr_d  = pick_d ? d_req_addr : i_req_addr;
        write_d = pick_d && d_req_write;
      end
      CMD: begin
        mem_req_valid = 1'b1;
        i_req_ready   = mem_req_ready && grant_q == GNT_I;
        d_req_ready   = mem_req_ready && grant_q == GNT_D;
        state_d       = !mem_req_ready ? CMD : write_q ? WDATA : RDATA;
      end
      RDATA: begin
        rd_beat = mem_rdata_valid;
        state_d = (rd_beat && cnt_last) ? IDLE : RDATA;
      end
      default: begin
        mem_wdata_valid = 1'b1;
        wr_beat         = mem_wdata_ready;
        state_d         = (wr_beat && cnt_last) ? IDLE : WDATA;
      end
    endcase
  end
  mem_arb_beat_counter #(.LINE_BEATS(LINE_BEATS)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == IDLE),
    .inc_i  (rd_beat || wr_beat),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );
  assign i_rdata_valid = rd_beat && grant_q == GNT_I;
  assign i_rdata_last  = i_rdata_valid && cnt_last;
  assign d_rdata_valid = rd_beat && grant_q == GNT_D;
  assign d_rdata_last  = (d_rdata_valid || wr_beat) && cnt_last;
  assign d_wdata_ready = wr_beat;
  assign d_wbeat       = cnt;
  assign mem_wdata     = d_wdata;
  assign rdata         = mem_rdata;
  assign mem_req_addr  = addr_q;
  assign mem_req_write = write_q;
  assign busy          = state_q != IDLE;
  // Read beats arriving outside a read burst are dropped; flag them.
  a_stray_rdata: assert property (@(posedge clk) disable iff (rst) !(mem_rdata_valid && state_q != RDATA))
    else $warning("mem_port_arbiter: mem_rdata_valid outside RDATA dropped");
  a_i_held: assert property (@(posedge clk) disable iff (rst) (state_q == CMD && grant_q == GNT_I) |-> i_req_valid);
  a_d_held: assert property (@(posedge clk) disable iff (rst) (state_q == CMD && grant_q == GNT_D) |-> d_req_valid);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized scenarios checked every cycle against a transaction-rule model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, LB = 4, CW = 2;
  logic clk = 1'b0, rst;
  logic i_req_valid, i_req_ready, i_rdata_valid, i_rdata_last;
  logic d_req_valid, d_req_write, d_req_ready, d_wdata_ready, d_rdata_valid, d_rdata_last;
  logic [AW-1:0] i_req_addr, d_req_addr, mem_req_addr;
  logic [DW-1:0] d_wdata, rdata, mem_wdata, mem_rdata;
  logic [CW-1:0] d_wbeat;
  logic mem_req_valid, mem_req_ready, mem_req_write, mem_wdata_valid, mem_wdata_ready, mem_rdata_valid, busy;
  logic [DW-1:0] wline [LB];
  int n_run = 0, n_fail = 0;
  // model: phase 0 idle, 1 command, 2 read beats, 3 write beats
  int m_ph = 0, m_beat = 0;
  bit m_gd = 0, m_last_d = 0, m_wr = 0;
  logic [AW-1:0] m_addr = '0;
  always #5 clk = ~clk;
  assign d_wdata = wline[d_wbeat];
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_BEATS(LB)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rdata_valid(i_rdata_valid), .i_rdata_last(i_rdata_last),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
    .d_wdata(d_wdata), .d_wbeat(d_wbeat), .d_wdata_ready(d_wdata_ready),
    .d_rdata_valid(d_rdata_valid), .d_rdata_last(d_rdata_last), .rdata(rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
    .mem_wdata(mem_wdata), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata), .busy(busy)
  );
  function automatic logic [127:0] exp_vec();
    bit cmd = m_ph == 1, rd = m_ph == 2, wr = m_ph == 3, lb = m_beat == LB - 1;
    bit brd = rd && mem_rdata_valid, bwr = wr && mem_wdata_ready;
    return {m_ph != 0, cmd, cmd && m_wr, cmd ? m_addr : AW'(0),
            cmd && mem_req_ready && !m_gd, cmd && mem_req_ready && m_gd,
            brd && !m_gd, brd && !m_gd && lb, brd && m_gd, m_gd && (brd || bwr) && lb,
            bwr, wr, wr ? CW'(m_beat) : CW'(0), wr ? wline[m_beat] : DW'(0), mem_rdata};
  endfunction
  function automatic logic [127:0] act_vec();
    return {busy, mem_req_valid, mem_req_valid && mem_req_write, mem_req_valid ? mem_req_addr : AW'(0),
            i_req_ready, d_req_ready, i_rdata_valid, i_rdata_last, d_rdata_valid, d_rdata_last,
            d_wdata_ready, mem_wdata_valid, mem_wdata_valid ? d_wbeat : CW'(0),
            mem_wdata_valid ? mem_wdata : DW'(0), rdata};
  endfunction
  // Advance the model with this cycle's inputs, cross the clock edge, then let the caches drop accepted requests.
  task automatic tick();
    bit acc = m_ph == 1 && mem_req_ready;
    bit ad = m_gd;
    if (rst) begin
      m_ph = 0; m_beat = 0; m_last_d = 0;
    end else case (m_ph)
      0: if (i_req_valid || d_req_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        m_gd = d_req_valid && !(i_req_valid && m_last_d);
`else
        m_gd = d_req_valid;
`endif
        m_last_d = m_gd;
        m_addr = m_gd ? d_req_addr : i_req_addr;
        m_wr = m_gd && d_req_write;
        m_ph = 1;
      end
      1: if (mem_req_ready) m_ph = m_wr ? 3 : 2;
      default: if ((m_ph == 2 && mem_rdata_valid) || (m_ph == 3 && mem_wdata_ready)) begin
        m_beat = (m_beat + 1) % LB;
        if (m_beat == 0) m_ph = 0;
      end
    endcase
    @(posedge clk);
    #1;
    if (acc) begin
      if (ad) d_req_valid = 1'b0;
      else i_req_valid = 1'b0;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2; n_run++;
      if (act_vec() !== exp_vec()) begin n_fail++; $display("FAIL reset cyc%0d got=%h exp=%h", c, act_vec(), exp_vec()); end
      tick();
    end
    rst = 1'b0;
  endtask
  task automatic test_i_refill();
    int nv = 0, nl = 0;
    i_req_valid = 1'b1; i_req_addr = 'h40; mem_req_ready = 1'b1; mem_wdata_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mem_rdata_valid = m_ph == 2;
      mem_rdata = DW'('hA0 + m_beat);
      #2; n_run++;
      if (act_vec() !== exp_vec()) begin n_fail++; $display("FAIL i_refill cyc%0d got=%h exp=%h", c, act_vec(), exp_vec()); end
      nv += int'(i_rdata_valid); nl += int'(i_rdata_last);
      tick();
    end
    n_run++;
    if (nv !== 4 || nl !== 1) begin n_fail++; $display("FAIL i_refill_count got=%0d/%0d exp=4/1", nv, nl); end
    mem_rdata_valid = 1'b0;
  endtask
  task automatic test_writeback();
    bit pat [6] = '{1, 0, 1, 1, 0, 1};
    int p = 0, np = 0, nl = 0;
    for (int k = 0; k < LB; k++) wline[k] = $urandom;
    d_req_valid = 1'b1; d_req_write = 1'b1; d_req_addr = 'h80; mem_req_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      mem_wdata_ready = (m_ph == 3 && p < 6) ? pat[p] : 1'b0;
      if (m_ph == 3) p++;
      #2; n_run++;
      if (act_vec() !== exp_vec()) begin n_fail++; $display("FAIL writeback cyc%0d got=%h exp=%h", c, act_vec(), exp_vec()); end
      np += int'(d_wdata_ready); nl += int'(d_rdata_last);
      tick();
    end
    n_run++;
    if (np !== 4 || nl !== 1) begin n_fail++; $display("FAIL writeback_count got=%0d/%0d exp=4/1", np, nl); end
    mem_wdata_ready = 1'b0;
  endtask
  task automatic test_priority();
    int first = -1;
    bit exp_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_d = !m_last_d;
`else
    exp_d = 1'b1;
`endif
    i_req_valid = 1'b1; i_req_addr = 'h100; d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = 'h200;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      mem_rdata_valid = m_ph == 2; mem_rdata = $urandom;
      #2; n_run++;
      if (act_vec() !== exp_vec()) begin n_fail++; $display("FAIL priority cyc%0d got=%h exp=%h", c, act_vec(), exp_vec()); end
      if (first < 0 && (i_req_ready || d_req_ready)) first = int'(d_req_ready);
      tick();
    end
    n_run++;
    if (first !== int'(exp_d)) begin n_fail++; $display("FAIL priority_first got_d=%0d exp_d=%0d", first, exp_d); end
    mem_rdata_valid = 1'b0;
  endtask
  task automatic test_cmd_stall();
    int st = 0, nr = 0;
    d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = 'h300;
    for (int c = 0; c < 14; c++) begin
      mem_req_ready = m_ph == 1 && st >= 5;
      if (m_ph == 1) st++;
      mem_rdata_valid = m_ph == 2; mem_rdata = $urandom;
      #2; n_run++;
      if (act_vec() !== exp_vec()) begin n_fail++; $display("FAIL cmd_stall cyc%0d got=%h exp=%h", c, act_vec(), exp_vec()); end
      nr += int'(d_req_ready);
      tick();
    end
    n_run++;
    if (nr !== 1) begin n_fail++; $display("FAIL cmd_stall_ready got=%0d exp=1", nr); end
    mem_rdata_valid = 1'b0;
  endtask
  task automatic test_reset_mid();
    int nl = 0;
    i_req_valid = 1'b1; i_req_addr = 'h500; mem_req_ready = 1'b1;
    for (int c = 0; c < 10 && !(m_ph == 2 && m_beat == 2); c++) begin
      mem_rdata_valid = m_ph == 2; mem_rdata = $urandom;
      #2; n_run++;
      if (act_vec() !== exp_vec()) begin n_fail++; $display("FAIL reset_mid cyc%0d got=%h exp=%h", c, act_vec(), exp_vec()); end
      tick();
    end
    mem_rdata_valid = 1'b0; rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2; n_run++;
      if (act_vec() !== exp_vec()) begin n_fail++; $display("FAIL reset_mid_rst cyc%0d got=%h exp=%h", c, act_vec(), exp_vec()); end
      nl += int'(i_rdata_last || d_rdata_last);
      tick();
      rst = 1'b0;
    end
    for (int k = 0; k < LB; k++) wline[k] = $urandom;
    d_req_valid = 1'b1; d_req_write = 1'b1; d_req_addr = 'h600; mem_wdata_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #2; n_run++;
      if (act_vec() !== exp_vec()) begin n_fail++; $display("FAIL reset_mid_after cyc%0d got=%h exp=%h", c, act_vec(), exp_vec()); end
      tick();
    end
    n_run++;
    if (nl !== 0) begin n_fail++; $display("FAIL reset_mid_last got=%0d exp=0", nl); end
    mem_wdata_ready = 1'b0;
  endtask
  task automatic test_stray();
    mem_rdata_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      mem_rdata = $urandom;
      #2; n_run++;
      if (act_vec() !== exp_vec()) begin n_fail++; $display("FAIL stray cyc%0d got=%h exp=%h", c, act_vec(), exp_vec()); end
      tick();
    end
    mem_rdata_valid = 1'b0;
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bit drain = c >= 560;
      if (!drain && !i_req_valid && !(m_ph >= 2 && !m_gd) && $urandom_range(3) == 0) begin
        i_req_valid = 1'b1; i_req_addr = $urandom;
      end
      if (!drain && !d_req_valid && !(m_ph >= 2 && m_gd) && $urandom_range(3) == 0) begin
        d_req_valid = 1'b1; d_req_write = 1'($urandom_range(1)); d_req_addr = $urandom;
        for (int k = 0; k < LB; k++) wline[k] = $urandom;
      end
      rst = !drain && $urandom_range(149) == 0;
      mem_req_ready = 1'($urandom_range(1));
      mem_rdata_valid = m_ph == 2 && $urandom_range(1) == 1;
      mem_wdata_ready = 1'($urandom_range(1));
      mem_rdata = $urandom;
      #2; n_run++;
      if (act_vec() !== exp_vec()) begin n_fail++; $display("FAIL random cyc%0d got=%h exp=%h", c, act_vec(), exp_vec()); end
      tick();
    end
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_addr = '0; d_req_valid = 1'b0; d_req_write = 1'b0; d_req_addr = '0;
    mem_req_ready = 1'b0; mem_wdata_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
    for (int k = 0; k < LB; k++) wline[k] = $urandom;
    @(posedge clk);
    #1;
    test_reset();
    test_i_refill();
    test_writeback();
    test_priority();
    test_cmd_stall();
    test_reset_mid();
    test_stray();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
